// File: rtl/huffman_stream_encoder.sv
// huffman_stream_encoder: packs 4-bit weight symbols into a variable-length Huffman bitstream of 32-bit words
// Ports: clk/reset (sync, active-high); in_data/in_valid/in_ready/in_last accept 8-nibble words;
// out_data/out_valid/out_ready/out_last/out_nbits present packed code words; frame_bits = last frame's bit total; busy = not idle.
module huffman_stream_encoder #(
    parameter int SYM_PER_WORD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [5:0]  out_nbits,
    output logic [15:0] frame_bits,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0, ENCODE = 2'd1, FLUSH = 2'd2;
    logic [1:0]  state;
    logic [31:0] word;
    logic        last_r;
    logic [2:0]  idx;
    logic [38:0] acc, acc_e;
    logic [5:0]  acc_cnt, cnt_e;
    logic [15:0] run_cnt;
    logic [3:0]  sym;
    logic [6:0]  code;
    logic [2:0]  len;
    logic        slot_free, emit, fin, append, last_hs;
    assign in_ready = !reset && state == IDLE;
    assign busy     = state != IDLE;
    always_comb begin
        slot_free = !out_valid || out_ready;
        emit      = slot_free && acc_cnt >= 6'd32 && (state == ENCODE || state == FLUSH);
        // the final word goes out once; afterwards we only wait for its handshake
        fin       = state == FLUSH && slot_free && acc_cnt < 6'd32 && !(out_valid && out_last);
        acc_e     = emit ? acc >> 32 : acc;
        cnt_e     = emit ? acc_cnt - 6'd32 : acc_cnt;
        sym       = word[{idx, 2'b00} +: 4];
        // codes are stored first-emitted-bit in bit 0
        code      = sym == 4'd0  ? 7'd0 :
                    sym == 4'd1  ? 7'b0000001 :
                    sym == 4'd15 ? 7'b0000011 : {sym[0], sym[1], sym[2], sym[3], 3'b111};
        len       = sym == 4'd0 ? 3'd1 : sym == 4'd1 ? 3'd2 : sym == 4'd15 ? 3'd3 : 3'd7;
        append    = state == ENCODE && cnt_e < 6'd32;
        last_hs   = state == FLUSH && out_valid && out_last && out_ready;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word       <= '0;
            last_r     <= 1'b0;
            idx        <= '0;
            acc        <= '0;
            acc_cnt    <= '0;
            run_cnt    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_nbits  <= '0;
            frame_bits <= '0;
        end else begin
            if (emit || fin) begin
                out_data  <= acc[31:0];
                out_nbits <= emit ? 6'd32 : acc_cnt;
                out_last  <= fin;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (fin) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else if (append) begin
                acc     <= acc_e | ({32'd0, code} << cnt_e);
                acc_cnt <= cnt_e + {3'd0, len};
                run_cnt <= run_cnt + {13'd0, len};
                idx     <= idx + 3'd1;
            end else begin
                acc     <= acc_e;
                acc_cnt <= cnt_e;
            end
            if (state == IDLE && in_valid) begin
                word   <= in_data;
                last_r <= in_last;
                idx    <= '0;
                state  <= ENCODE;
            end
            if (append && idx == 3'(SYM_PER_WORD - 1))
                state <= last_r ? FLUSH : IDLE;
            if (last_hs) begin
                state      <= IDLE;
                frame_bits <= run_cnt;
                run_cnt    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_huffman_stream_encoder.sv
module tb_huffman_stream_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [5:0]  out_nbits;
    logic [15:0] frame_bits;
    logic        busy;
    int          cmp = 0;
    int          bad = 0;
    logic [31:0] cd[$];
    logic [5:0]  cn[$];
    logic        cl[$];

    huffman_stream_encoder #(.SYM_PER_WORD(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_nbits(out_nbits), .frame_bits(frame_bits), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!reset && out_valid && out_ready) begin
            cd.push_back(out_data);
            cn.push_back(out_nbits);
            cl.push_back(out_last);
        end

    task automatic clr();
        cd.delete();
        cn.delete();
        cl.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        in_data = d;
        in_last = l;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_last(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (cl.size() > 0 && cl[cl.size()-1]) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        cmp++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got in_ready/out_valid/out_last/busy=%b want 0000", {in_ready, out_valid, out_last, busy});
        end
        cmp++;
        if ({out_data, out_nbits, frame_bits} !== 54'd0) begin
            bad++;
            $display("FAIL reset_regs: got data=%h nbits=%0d frame_bits=%0d want 0/0/0", out_data, out_nbits, frame_bits);
        end
        reset = 1'b0;
        @(negedge clk);
        cmp++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_zeros();
        bit ok;
        clr();
        send(32'h0, 1'b1);
        wait_last(ok);
        cmp++;
        if (!ok || cd.size() != 1) begin
            bad++;
            $display("FAIL zeros_count: got %0d words (done=%b) want 1", cd.size(), ok);
        end else begin
            cmp++;
            if ({cd[0], cn[0], cl[0]} !== {32'h0, 6'd8, 1'b1}) begin
                bad++;
                $display("FAIL zeros_word: got data=%h nbits=%0d last=%b want 00000000/8/1", cd[0], cn[0], cl[0]);
            end
        end
        cmp++;
        if (frame_bits !== 16'd8) begin
            bad++;
            $display("FAIL zeros_frame: got %0d want 8", frame_bits);
        end
    endtask

    task automatic test_short();
        bit ok;
        clr();
        send(32'h0000F1F1, 1'b1);
        wait_last(ok);
        cmp++;
        if (!ok || cd.size() != 1) begin
            bad++;
            $display("FAIL short_count: got %0d words (done=%b) want 1", cd.size(), ok);
        end else begin
            cmp++;
            if ({cd[0], cn[0], cl[0]} !== {32'h000001AD, 6'd14, 1'b1}) begin
                bad++;
                $display("FAIL short_word: got data=%h nbits=%0d last=%b want 000001ad/14/1", cd[0], cn[0], cl[0]);
            end
        end
        cmp++;
        if (frame_bits !== 16'd14) begin
            bad++;
            $display("FAIL short_frame: got %0d want 14", frame_bits);
        end
    endtask

    task automatic check_escape(input string tag);
        cmp++;
        if (cd.size() != 2) begin
            bad++;
            $display("FAIL %s_count: got %0d words want 2", tag, cd.size());
        end else begin
            cmp++;
            if ({cd[0], cn[0], cl[0]} !== {32'h7AF5EBD7, 6'd32, 1'b0}) begin
                bad++;
                $display("FAIL %s_w0: got data=%h nbits=%0d last=%b want 7af5ebd7/32/0", tag, cd[0], cn[0], cl[0]);
            end
            cmp++;
            if ({cd[1], cn[1], cl[1]} !== {32'h00AF5EBD, 6'd24, 1'b1}) begin
                bad++;
                $display("FAIL %s_w1: got data=%h nbits=%0d last=%b want 00af5ebd/24/1", tag, cd[1], cn[1], cl[1]);
            end
        end
        cmp++;
        if (frame_bits !== 16'd56) begin
            bad++;
            $display("FAIL %s_frame: got %0d want 56", tag, frame_bits);
        end
    endtask

    task automatic test_escape();
        bit ok;
        clr();
        send(32'h55555555, 1'b1);
        wait_last(ok);
        check_escape("escape");
    endtask

    task automatic test_boundary();
        bit ok;
        clr();
        repeat (3) send(32'h0, 1'b0);
        send(32'h0, 1'b1);
        wait_last(ok);
        cmp++;
        if (!ok || cd.size() != 2) begin
            bad++;
            $display("FAIL boundary_count: got %0d words (done=%b) want 2", cd.size(), ok);
        end else begin
            cmp++;
            if ({cd[0], cn[0], cl[0]} !== {32'h0, 6'd32, 1'b0}) begin
                bad++;
                $display("FAIL boundary_w0: got data=%h nbits=%0d last=%b want 00000000/32/0", cd[0], cn[0], cl[0]);
            end
            cmp++;
            if ({cd[1], cn[1], cl[1]} !== {32'h0, 6'd0, 1'b1}) begin
                bad++;
                $display("FAIL boundary_w1: got data=%h nbits=%0d last=%b want 00000000/0/1", cd[1], cn[1], cl[1]);
            end
        end
        cmp++;
        if (frame_bits !== 16'd32) begin
            bad++;
            $display("FAIL boundary_frame: got %0d want 32", frame_bits);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable = 1'b1;
        int t = 0;
        clr();
        out_ready = 1'b0;
        send(32'h55555555, 1'b1);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_data !== 32'h7AF5EBD7 || in_ready !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        cmp++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_hold: got valid=%b data=%h in_ready=%b want 1/7af5ebd7/0 throughout", out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        wait_last(ok);
        check_escape("bp");
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr();
        out_ready = 1'b0;
        send(32'h55555555, 1'b1);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL rst_mid_state: got out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        cmp++;
        if (cd.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_stale: got %0d words after reset want 0", cd.size());
        end
        send(32'h0, 1'b1);
        wait_last(ok);
        cmp++;
        if (!ok || cd.size() != 1) begin
            bad++;
            $display("FAIL rst_mid_count: got %0d words (done=%b) want 1", cd.size(), ok);
        end else begin
            cmp++;
            if ({cd[0], cn[0], cl[0]} !== {32'h0, 6'd8, 1'b1}) begin
                bad++;
                $display("FAIL rst_mid_word: got data=%h nbits=%0d last=%b want 00000000/8/1", cd[0], cn[0], cl[0]);
            end
        end
        cmp++;
        if (frame_bits !== 16'd8) begin
            bad++;
            $display("FAIL rst_mid_frame: got %0d want 8", frame_bits);
        end
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_short();
        test_escape();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
